// File: rtl/sweep_ctrl_pkg.sv
// sweep_ctrl_pkg: shared state encoding and default widths for the sweep sequencer
// Contents: W_DEF/DW_DEF default word widths, state_t FSM encoding.
package sweep_ctrl_pkg;
    localparam int W_DEF  = 16;
    localparam int DW_DEF = 16;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/sweep_ctrl_if.sv
// sweep_ctrl_if: control/config and status bundle between the SPI register chain and the sweep sequencer
// Ports: master drives start/abort/cont and config words, reads step/status;
//        slave (the sequencer) reads config, drives o_step/o_sel_sine/o_busy/o_step_stb/o_done.
interface sweep_ctrl_if import sweep_ctrl_pkg::*; #(
    parameter int W  = W_DEF,
    parameter int DW = DW_DEF
) ();
    logic          i_start;
    logic          i_abort;
    logic          i_cont;
    logic [W-1:0]  i_start_step;
    logic [W-1:0]  i_stop_step;
    logic [W-1:0]  i_inc;
    logic [DW-1:0] i_dwell;
    logic [W-1:0]  o_step;
    logic          o_sel_sine;
    logic          o_busy;
    logic          o_step_stb;
    logic          o_done;
    modport master (
        output i_start, i_abort, i_cont, i_start_step, i_stop_step, i_inc, i_dwell,
        input  o_step, o_sel_sine, o_busy, o_step_stb, o_done
    );
    modport slave (
        input  i_start, i_abort, i_cont, i_start_step, i_stop_step, i_inc, i_dwell,
        output o_step, o_sel_sine, o_busy, o_step_stb, o_done
    );
endinterface

// File: rtl/sweep_ctrl_dwell_timer.sv
// dwell_timer: loadable down-counter that stops at zero and flags it
// Ports: i_clk, i_rst (sync, active high), i_clr (force to 0), i_load/i_val (load value),
//        o_zero (count is zero).
module dwell_timer import sweep_ctrl_pkg::*; #(
    parameter int DW = DW_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_load,
    input  logic [DW-1:0] i_val,
    output logic          o_zero
);
    logic [DW-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = i_clr ? '0 : i_load ? i_val : (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
    assign o_zero = (cnt_q == '0);
endmodule

// File: rtl/sweep_ctrl.sv
// sweep_ctrl: frequency-sweep sequencer stepping the sine generator phase increment
// Ports: i_clk, i_rst (sync, active high), bus (sweep_ctrl_if.slave): start/abort/cont and
//        start/stop/inc/dwell config in; o_step, o_sel_sine, o_busy, o_step_stb, o_done out.
module sweep_ctrl import sweep_ctrl_pkg::*; #(
    parameter int W  = W_DEF,
    parameter int DW = DW_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    sweep_ctrl_if.slave bus
);
    state_t        state_q, state_d;
    logic [W-1:0]  step_q, step_d;
    logic [W-1:0]  sh_start_q, sh_stop_q, sh_inc_q;
    logic [DW-1:0] sh_dwell_q, dw_src, reload;
    logic          sh_cont_q;
    logic          sel_q, sel_d, stb_q, stb_d;
    logic          go, load, clr, zero, adv;
    logic [W:0]    nxt;
    // One extra bit so a step past 2^W-1 compares greater than any stop instead of wrapping.
    assign nxt = {1'b0, step_q} + {1'b0, sh_inc_q};
    assign adv = (nxt <= {1'b0, sh_stop_q}) && (sh_inc_q != '0);
    // On the start cycle the shadow registers are not yet loaded, so reload from the live input.
    assign dw_src = go ? bus.i_dwell : sh_dwell_q;
    assign reload = (dw_src == '0) ? '0 : dw_src - 1'b1;
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        sel_d   = sel_q;
        stb_d   = 1'b0;
        go      = 1'b0;
        load    = 1'b0;
        clr     = 1'b0;
        if (bus.i_abort) begin
            state_d = ST_IDLE;
            step_d  = '0;
            sel_d   = 1'b0;
            clr     = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        go      = 1'b1;
                        load    = 1'b1;
                        step_d  = bus.i_start_step;
                        sel_d   = 1'b1;
                        stb_d   = 1'b1;
                        state_d = ST_DWELL;
                    end
                end
                ST_DWELL: begin
                    if (zero) begin
                        if (adv || sh_cont_q) begin
                            step_d = adv ? nxt[W-1:0] : sh_start_q;
                            stb_d  = 1'b1;
                            load   = 1'b1;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            step_q     <= '0;
            sel_q      <= 1'b0;
            stb_q      <= 1'b0;
            sh_start_q <= '0;
            sh_stop_q  <= '0;
            sh_inc_q   <= '0;
            sh_dwell_q <= '0;
            sh_cont_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            sel_q   <= sel_d;
            stb_q   <= stb_d;
            if (go) begin
                sh_start_q <= bus.i_start_step;
                sh_stop_q  <= bus.i_stop_step;
                sh_inc_q   <= bus.i_inc;
                sh_dwell_q <= bus.i_dwell;
                sh_cont_q  <= bus.i_cont;
            end
        end
    end
    dwell_timer #(.DW(DW)) u_timer (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (clr),
        .i_load (load),
        .i_val  (reload),
        .o_zero (zero)
    );
    assign bus.o_step     = step_q;
    assign bus.o_sel_sine = sel_q;
    assign bus.o_step_stb = stb_q;
    assign bus.o_busy     = (state_q == ST_DWELL);
    assign bus.o_done     = (state_q == ST_DONE);
endmodule

// File: tb/tb_sweep_ctrl.sv
// tb_sweep_ctrl: randomized self-checking bench for sweep_ctrl against a per-cycle sequence model
module tb_sweep_ctrl;
    typedef struct packed {
        logic [15:0] step;
        logic        stb;
        logic        busy;
        logic        done;
        logic        sel;
    } obs_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    sweep_ctrl_if #(.W(16), .DW(16)) bus ();
    sweep_ctrl #(.W(16), .DW(16)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    function automatic obs_t sample();
        return obs_t'({bus.o_step, bus.o_step_stb, bus.o_busy, bus.o_done, bus.o_sel_sine});
    endfunction
    function automatic string str(obs_t o);
        return $sformatf("step=%h stb=%b busy=%b done=%b sel=%b", o.step, o.stb, o.busy, o.done, o.sel);
    endfunction
    // Expected outputs, one entry per cycle from the first cycle after the start request:
    // every value start, start+inc, ... not exceeding stop is held max(dwell,1) cycles
    // (strobe on its first cycle), then a single done cycle unless repeating.
    function automatic void build(input int start, input int stop, input int inc, input int dwell,
                                  input bit cont, input int maxc, output obs_t q[$]);
        int d = (dwell == 0) ? 1 : dwell;
        int v = start;
        q = {};
        while (q.size() < maxc) begin
            for (int k = 0; k < d; k++) q.push_back(obs_t'({v[15:0], k == 0, 1'b1, 1'b0, 1'b1}));
            if (inc != 0 && v + inc <= stop) v += inc;
            else if (cont) v = start;
            else begin
                q.push_back(obs_t'({v[15:0], 1'b0, 1'b0, 1'b1, 1'b1}));
                break;
            end
        end
    endfunction
    task automatic kick(input int s, input int p, input int i, input int d, input bit c);
        bus.i_start_step = s[15:0];
        bus.i_stop_step  = p[15:0];
        bus.i_inc        = i[15:0];
        bus.i_dwell      = d[15:0];
        bus.i_cont       = c;
        bus.i_start      = 1'b1;
        tick();
        bus.i_start      = 1'b0;
    endtask
    task automatic test_reset;
        obs_t o;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        o = sample();
        checks++;
        if (o !== '0) begin
            errors++;
            $display("FAIL reset: got %s want %s", str(o), str('0));
        end
    endtask
    task automatic test_basic;
        obs_t q[$];
        obs_t o;
        build(100, 400, 100, 4, 0, 1000, q);
        kick(100, 400, 100, 4, 0);
        foreach (q[n]) begin
            o = sample();
            checks++;
            if (o !== q[n]) begin
                errors++;
                $display("FAIL basic cyc %0d: got %s want %s", n, str(o), str(q[n]));
            end
            tick();
        end
        o = sample();
        checks++;
        if (o !== obs_t'({16'd400, 4'b0001})) begin
            errors++;
            $display("FAIL basic_idle: got %s want step=0190 sel=1 rest 0", str(o));
        end
    endtask
    task automatic test_dwell0;
        obs_t q[$];
        obs_t o;
        build(10, 12, 1, 0, 0, 1000, q);
        kick(10, 12, 1, 0, 0);
        foreach (q[n]) begin
            o = sample();
            checks++;
            if (o !== q[n]) begin
                errors++;
                $display("FAIL dwell0 cyc %0d: got %s want %s", n, str(o), str(q[n]));
            end
            tick();
        end
    endtask
    task automatic test_overflow;
        obs_t q[$];
        obs_t o;
        build(16'hFF00, 16'hFFFF, 16'h0200, 2, 0, 1000, q);
        kick(16'hFF00, 16'hFFFF, 16'h0200, 2, 0);
        foreach (q[n]) begin
            o = sample();
            checks++;
            if (o !== q[n]) begin
                errors++;
                $display("FAIL overflow cyc %0d: got %s want %s", n, str(o), str(q[n]));
            end
            tick();
        end
    endtask
    task automatic test_continuous;
        obs_t q[$];
        obs_t o;
        build(5, 7, 1, 1, 1, 20, q);
        kick(5, 7, 1, 1, 1);
        foreach (q[n]) begin
            o = sample();
            checks++;
            if (o !== q[n]) begin
                errors++;
                $display("FAIL cont cyc %0d: got %s want %s", n, str(o), str(q[n]));
            end
            tick();
        end
        bus.i_abort = 1'b1;
        tick();
        bus.i_abort = 1'b0;
        for (int k = 0; k < 2; k++) begin
            o = sample();
            checks++;
            if (o !== '0) begin
                errors++;
                $display("FAIL cont_abort %0d: got %s want %s", k, str(o), str('0));
            end
            tick();
        end
    endtask
    task automatic test_start_abort;
        obs_t o;
        bus.i_start_step = 16'd33;
        bus.i_stop_step  = 16'd99;
        bus.i_inc        = 16'd1;
        bus.i_dwell      = 16'd3;
        bus.i_start      = 1'b1;
        bus.i_abort      = 1'b1;
        tick();
        bus.i_start      = 1'b0;
        bus.i_abort      = 1'b0;
        for (int k = 0; k < 2; k++) begin
            o = sample();
            checks++;
            if (o !== '0) begin
                errors++;
                $display("FAIL start_abort %0d: got %s want %s", k, str(o), str('0));
            end
            tick();
        end
    endtask
    task automatic test_ignored;
        obs_t q[$];
        obs_t o;
        int s = $urandom_range(0, 1000);
        int p = s + $urandom_range(200, 2000);
        int i = $urandom_range(50, 400);
        int d = $urandom_range(0, 4);
        build(s, p, i, d, 0, 1000, q);
        kick(s, p, i, d, 0);
        foreach (q[n]) begin
            o = sample();
            checks++;
            if (o !== q[n]) begin
                errors++;
                $display("FAIL ignored cyc %0d: got %s want %s", n, str(o), str(q[n]));
            end
            bus.i_start_step = 16'($urandom);
            bus.i_stop_step  = 16'($urandom);
            bus.i_inc        = 16'($urandom);
            bus.i_dwell      = 16'($urandom_range(0, 7));
            bus.i_cont       = 1'($urandom);
            bus.i_start      = (n == q.size() - 1) ? 1'b1 : 1'($urandom);
            tick();
        end
        bus.i_start = 1'b0;
        bus.i_cont  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            o = sample();
            checks++;
            if (o !== obs_t'({q[q.size()-1].step, 4'b0001})) begin
                errors++;
                $display("FAIL ignored_idle %0d: got %s want step=%h sel=1 rest 0", k, str(o), q[q.size()-1].step);
            end
            tick();
        end
    endtask
    task automatic test_reset_mid;
        obs_t q[$];
        obs_t o;
        kick(1000, 5000, 1000, 3, 1);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            o = sample();
            checks++;
            if (o !== '0) begin
                errors++;
                $display("FAIL reset_mid %0d: got %s want %s", k, str(o), str('0));
            end
            tick();
        end
        build(7, 9, 1, 2, 0, 1000, q);
        kick(7, 9, 1, 2, 0);
        foreach (q[n]) begin
            o = sample();
            checks++;
            if (o !== q[n]) begin
                errors++;
                $display("FAIL reset_rerun cyc %0d: got %s want %s", n, str(o), str(q[n]));
            end
            tick();
        end
    endtask
    task automatic test_random;
        obs_t q[$];
        obs_t o;
        for (int it = 0; it < 25; it++) begin
            int r = $urandom_range(0, 7);
            int s = $urandom_range(0, 65535);
            int p = (r == 0 && s > 0) ? $urandom_range(0, s - 1) : s + $urandom_range(0, 3000);
            int i = (r == 1) ? 0 : $urandom_range(150, 700);
            int d = $urandom_range(0, 5);
            if (p > 65535) p = 65535;
            build(s, p, i, d, 0, 1000, q);
            kick(s, p, i, d, 0);
            foreach (q[n]) begin
                o = sample();
                checks++;
                if (o !== q[n]) begin
                    errors++;
                    $display("FAIL random it %0d cyc %0d: got %s want %s", it, n, str(o), str(q[n]));
                end
                tick();
            end
            o = sample();
            checks++;
            if (o !== obs_t'({q[q.size()-1].step, 4'b0001})) begin
                errors++;
                $display("FAIL random_idle it %0d: got %s want step=%h sel=1 rest 0", it, str(o), q[q.size()-1].step);
            end
        end
    endtask
    initial begin
        bus.i_start      = 1'b0;
        bus.i_abort      = 1'b0;
        bus.i_cont       = 1'b0;
        bus.i_start_step = '0;
        bus.i_stop_step  = '0;
        bus.i_inc        = '0;
        bus.i_dwell      = '0;
        test_reset();
        test_basic();
        test_dwell0();
        test_overflow();
        test_continuous();
        test_start_abort();
        test_ignored();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sweep_ctrl.md
Name: sweep_ctrl

Overview:
- Frequency-sweep sequencer for the sine generator / delta-sigma DAC path.
- Steps the sine generator's phase-increment word (step) from a programmed start to a programmed stop in fixed increments.
- Holds each step for a programmed dwell count, with single-shot or continuous repeat.
- Drives the step word and the sine/register source select; configuration comes from the SPI register chain.

Parameters:
- W, 16, width of step/start/stop/increment words (matches sine generator step input)
- DW, 16, width of dwell counter

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active high
- i_start  in  1  start request; sampled in IDLE only
- i_abort  in  1  abort request; any state
- i_cont  in  1  1 = restart sweep at start after stop reached; sampled at i_start
- i_start_step  in  W  first step value
- i_stop_step  in  W  last permitted step value
- i_inc  in  W  increment per step
- i_dwell  in  DW  cycles each step is held; 0 treated as 1
- o_step  out  W  step word to sine generator
- o_sel_sine  out  1  1 = DAC source is sine generator
- o_busy  out  1  sweep in progress
- o_step_stb  out  1  one-cycle pulse on each new o_step value
- o_done  out  1  one-cycle pulse on sweep completion

Behaviour:
- One clock (i_clk); reset synchronous, active high (i_rst).
- Reset: state IDLE; o_step=0, o_sel_sine=0, o_busy=0, o_step_stb=0, o_done=0; dwell counter=0.
- States: IDLE, DWELL, DONE.
- IDLE:
  - i_start=1 and i_abort=0 latches start/stop/inc/dwell/cont into shadow registers (config inputs may change afterwards).
  - Next cycle: o_step=start, o_step_stb=1, o_sel_sine=1, o_busy=1, counter=max(dwell,1)-1, state DWELL.
- DWELL:
  - Counter decrements each cycle while nonzero.
  - When counter=0, evaluate next = o_step + inc in W+1 bits.
  - If next <= stop and inc != 0: o_step<=next[W-1:0], o_step_stb=1, counter reloaded, stay DWELL.
  - Else if cont=1: o_step<=start, o_step_stb=1, counter reloaded, stay DWELL.
  - Else: state DONE.
- Each step value is held exactly max(dwell,1) cycles; no gap cycle between steps.
- DONE (one cycle):
  - o_done=1, o_busy=0; o_step holds last value; o_sel_sine stays 1.
  - Then IDLE.
- After completion, o_sel_sine stays 1 until the next abort or reset, so the last tone persists.
- Abort: in any state, i_abort=1 gives next cycle IDLE, o_step=0, o_sel_sine=0, o_busy=0, no o_done pulse. Abort wins over start in the same cycle.
- i_start while not IDLE: ignored. i_start in the DONE cycle: ignored; must be reasserted in IDLE.
- Boundary cases:
  - stop < start: start is emitted for one dwell, then DONE (or repeats start forever if cont).
  - inc=0: same as stop < start.
  - Overflow: W+1-bit compare guarantees no wrap past 2^W-1.
- o_step_stb and o_done are never high in the same cycle.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, DWELL=2'd1, DONE=2'd2)
  - W and DW defaults
- Sub-module dwell_timer: loadable down-counter with zero flag.
- Top-level integration feeds o_step into the sine generator step input.
- o_sel_sine ORs with ui_in[6] for the DAC mux select.

Test Plan:
- Basic sweep: start=100, stop=400, inc=100, dwell=4, cont=0 -> o_step 100,200,300,400, each held 4 cycles; o_step_stb on each change; o_done pulses 1 cycle after the last 400 cycle; o_busy low at the o_done cycle.
- Dwell=0: start=10, stop=12, inc=1 -> o_step 10,11,12 on consecutive cycles, then o_done.
- Overflow guard: start=0xFF00, stop=0xFFFF, inc=0x0200, dwell=2 -> only 0xFF00 for 2 cycles, then o_done; never 0x0100.
- Continuous: start=5, stop=7, inc=1, dwell=1, cont=1 -> sequence 5,6,7,5,6,7... with no o_done; i_abort -> next cycle o_step=0, o_sel_sine=0, o_busy=0, no o_done.
- Simultaneous/ignored: i_start and i_abort together in IDLE -> stays IDLE. i_start mid-sweep -> sweep unchanged. Config inputs changed mid-sweep -> shadow values still used.
- Reset mid-sweep: assert i_rst during DWELL -> next cycle all outputs 0, state IDLE; a later i_start runs a clean sweep from start.
